dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: instruction fetch (read-only) and load/store (read/write with access size).
- Sits between the core's fetch and LSU front-ends and the memory macro interface.
- Resolves contention with fixed data-priority plus an anti-starvation streak limit.
- Tracks one outstanding read, steers its response to the owner, and times out hung reads.

---
 rtl/dmem_arbiter_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arb_timer.sv | 27 ++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        Byte_Access     = 2'b00,
        Halfword_Access = 2'b01,
        Word_Access     = 2'b10,
        Reserved        = 2'b11
    } access_size_e;

    typedef enum logic {
        OWNER_INSTR,
        OWNER_DATA
    } arb_owner_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_RESP
    } arb_state_e;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Memory-side request/response bus of the arbiter; master = arbiter, slave = memory macro.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    access_size_e mem_byte_en_o;
    logic         mem_wr_o;
    logic [31:0]  mem_wr_data_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/dmem_arb_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
module dmem_arb_timer #(
    parameter int TERMINAL = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] TC = 8'(TERMINAL);

    logic [7:0] count;

    // Holds at the terminal value so the flag stays stable until cleared.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != TC)) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = (count == TC);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; one outstanding read with timeout.
// Optional perf counters enabled by defining DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_req_i,
    input  logic [31:0]  instr_addr_i,
    output logic         instr_gnt_o,
    output logic         instr_rvalid_o,
    output logic [31:0]  instr_rdata_o,
    input  logic         data_req_i,
    input  logic [31:0]  data_addr_i,
    input  access_size_e data_byte_en_i,
    input  logic         data_wr_i,
    input  logic [31:0]  data_wr_data_i,
    output logic         data_gnt_o,
    output logic         data_rvalid_o,
    output logic [31:0]  data_rdata_o,
    output logic         bus_err_o,
    dmem_arbiter_if.master mem
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]  instr_grant_cnt_o,
    output logic [31:0]  data_grant_cnt_o,
    output logic [31:0]  stall_cnt_o
`endif
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_e state, next_state;
    arb_owner_e owner;
    logic [3:0] streak;
    logic       instr_wins;
    logic       handshake;
    logic       read_hs;
    logic       timer_tc;

    dmem_arb_timer #(
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (read_hs),
        .enable   (state == ARB_WAIT_RESP),
        .terminal (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARB_IDLE;
            owner  <= OWNER_DATA;
            streak <= '0;
        end else begin
            state <= next_state;
            if (read_hs) begin
                owner <= instr_wins ? OWNER_INSTR : OWNER_DATA;
            end
            // Streak only counts data wins that actually held off a waiting fetch.
            if (handshake) begin
                if (!instr_wins && instr_req_i) begin
                    streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
                end else begin
                    streak <= '0;
                end
            end
        end
    end

    always_comb begin
        next_state        = state;
        instr_wins        = 1'b0;
        handshake         = 1'b0;
        read_hs           = 1'b0;
        instr_gnt_o       = 1'b0;
        instr_rvalid_o    = 1'b0;
        instr_rdata_o     = '0;
        data_gnt_o        = 1'b0;
        data_rvalid_o     = 1'b0;
        data_rdata_o      = '0;
        bus_err_o         = 1'b0;
        mem.mem_req_o     = 1'b0;
        mem.mem_addr_o    = '0;
        mem.mem_byte_en_o = Byte_Access;
        mem.mem_wr_o      = 1'b0;
        mem.mem_wr_data_o = '0;

        if (!reset) begin
            unique case (state)
                ARB_IDLE: begin
                    instr_wins    = instr_req_i && (!data_req_i || (streak == STREAK_MAX));
                    mem.mem_req_o = instr_req_i | data_req_i;
                    if (instr_wins) begin
                        mem.mem_addr_o    = instr_addr_i;
                        mem.mem_byte_en_o = Word_Access;
                        instr_gnt_o       = mem.mem_gnt_i;
                    end else if (data_req_i) begin
                        mem.mem_addr_o    = data_addr_i;
                        mem.mem_byte_en_o = data_byte_en_i;
                        mem.mem_wr_o      = data_wr_i;
                        mem.mem_wr_data_o = data_wr_data_i;
                        data_gnt_o        = mem.mem_gnt_i;
                    end
                    handshake = mem.mem_req_o & mem.mem_gnt_i;
                    read_hs   = handshake & ~mem.mem_wr_o;
                    if (read_hs) begin
                        next_state = ARB_WAIT_RESP;
                    end
                end
                ARB_WAIT_RESP: begin
                    // A real response beats a coincident timeout.
                    if (mem.mem_rvalid_i || timer_tc) begin
                        next_state = ARB_IDLE;
                        bus_err_o  = ~mem.mem_rvalid_i;
                        if (owner == OWNER_INSTR) begin
                            instr_rvalid_o = 1'b1;
                            instr_rdata_o  = mem.mem_rvalid_i ? mem.mem_rdata_i : ARB_TIMEOUT_RDATA;
                        end else begin
                            data_rvalid_o = 1'b1;
                            data_rdata_o  = mem.mem_rvalid_i ? mem.mem_rdata_i : ARB_TIMEOUT_RDATA;
                        end
                    end
                end
                default: next_state = ARB_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_grant_cnt_o <= '0;
            data_grant_cnt_o  <= '0;
            stall_cnt_o       <= '0;
        end else begin
            if (handshake && instr_wins) begin
                instr_grant_cnt_o <= instr_grant_cnt_o + 32'd1;
            end
            if (handshake && !instr_wins) begin
                data_grant_cnt_o <= data_grant_cnt_o + 32'd1;
            end
            if ((instr_req_i || data_req_i) && !instr_gnt_o && !data_gnt_o) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default parameters 4 / 16).
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic         clk;
    logic         reset;
    logic         instr_req_i;
    logic [31:0]  instr_addr_i;
    logic         instr_gnt_o;
    logic         instr_rvalid_o;
    logic [31:0]  instr_rdata_o;
    logic         data_req_i;
    logic [31:0]  data_addr_i;
    access_size_e data_byte_en_i;
    logic         data_wr_i;
    logic [31:0]  data_wr_data_i;
    logic         data_gnt_o;
    logic         data_rvalid_o;
    logic [31:0]  data_rdata_o;
    logic         bus_err_o;

    int total;
    int bad;

    dmem_arbiter_if mem_bus ();

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] instr_grant_cnt;
    logic [31:0] data_grant_cnt;
    logic [31:0] stall_cnt;
`endif

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_byte_en_i (data_byte_en_i),
        .data_wr_i      (data_wr_i),
        .data_wr_data_i (data_wr_data_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .bus_err_o      (bus_err_o),
        .mem            (mem_bus)
`ifdef DMEM_ARB_PERF_CNT_EN
        ,
        .instr_grant_cnt_o (instr_grant_cnt),
        .data_grant_cnt_o  (data_grant_cnt),
        .stall_cnt_o       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic applyStimulus(input logic rst, input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic [31:0] daddr,
                                 input access_size_e dbe, input logic dwr,
                                 input logic [31:0] dwdata, input logic gnt,
                                 input logic rvalid, input logic [31:0] rdata);
        @(negedge clk);
        reset                = rst;
        instr_req_i          = ireq;
        instr_addr_i         = iaddr;
        data_req_i           = dreq;
        data_addr_i          = daddr;
        data_byte_en_i       = dbe;
        data_wr_i            = dwr;
        data_wr_data_i       = dwdata;
        mem_bus.mem_gnt_i    = gnt;
        mem_bus.mem_rvalid_i = rvalid;
        mem_bus.mem_rdata_i  = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Both requesters hold load requests; memory grants and answers at once.
    task automatic runContention(input int n, input logic [9:0] instr_first);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 1, 32'h1000, 1, 32'h2000, Word_Access, 0, 0, 1, 0, 0);
            checkOutput($sformatf("cont_igt%0d", i), 32'(instr_gnt_o), 32'(instr_first[i]));
            checkOutput($sformatf("cont_dgt%0d", i), 32'(data_gnt_o), 32'(!instr_first[i]));
            applyStimulus(0, 1, 32'h1000, 1, 32'h2000, Word_Access, 0, 0, 1, 1, 32'h100 + 32'(i));
            checkOutput($sformatf("cont_irv%0d", i), 32'(instr_rvalid_o), 32'(instr_first[i]));
            checkOutput($sformatf("cont_drv%0d", i), 32'(data_rvalid_o), 32'(!instr_first[i]));
            checkOutput($sformatf("cont_rd%0d", i),
                        instr_first[i] ? instr_rdata_o : data_rdata_o, 32'h100 + 32'(i));
            checkOutput($sformatf("cont_gap%0d", i), 32'(mem_bus.mem_req_o), 32'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        applyStimulus(1, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h40, 1, 32'h80, Word_Access, 0, 0, 1, 1, 32'h1);
        checkOutput("rst_mem_req", 32'(mem_bus.mem_req_o), 32'd0);
        checkOutput("rst_igt", 32'(instr_gnt_o), 32'd0);
        checkOutput("rst_dgt", 32'(data_gnt_o), 32'd0);
        checkOutput("rst_rv", 32'({instr_rvalid_o, data_rvalid_o, bus_err_o}), 32'd0);

        // Fetch-only read.
        applyStimulus(0, 1, 32'h100, 0, 0, Byte_Access, 0, 0, 1, 0, 0);
        checkOutput("fo_igt", 32'(instr_gnt_o), 32'd1);
        checkOutput("fo_dgt", 32'(data_gnt_o), 32'd0);
        checkOutput("fo_addr", mem_bus.mem_addr_o, 32'h100);
        checkOutput("fo_be", 32'(mem_bus.mem_byte_en_o), 32'(Word_Access));
        checkOutput("fo_wr", 32'(mem_bus.mem_wr_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 1, 1, 32'h13);
        checkOutput("fo_irv", 32'(instr_rvalid_o), 32'd1);
        checkOutput("fo_ird", instr_rdata_o, 32'h13);
        checkOutput("fo_drv", 32'(data_rvalid_o), 32'd0);
        checkOutput("fo_drd", data_rdata_o, 32'd0);

        runContention(10, 10'b10000_10000);

        // Store stream.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 32'h300 + 32'(i), Byte_Access, 1, 32'hA5, 1, 0, 0);
            checkOutput($sformatf("st_dgt%0d", i), 32'(data_gnt_o), 32'd1);
            checkOutput($sformatf("st_wr%0d", i), 32'(mem_bus.mem_wr_o), 32'd1);
            checkOutput($sformatf("st_be%0d", i), 32'(mem_bus.mem_byte_en_o), 32'(Byte_Access));
            checkOutput($sformatf("st_wd%0d", i), mem_bus.mem_wr_data_o, 32'hA5);
            checkOutput($sformatf("st_rv%0d", i), 32'(data_rvalid_o), 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        checkOutput("st_after_rv", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);

        // Timeout: grant, then 15 silent cycles, error on the 16th waiting cycle.
        applyStimulus(0, 0, 0, 1, 32'h200, Word_Access, 0, 0, 1, 0, 0);
        checkOutput("to_dgt", 32'(data_gnt_o), 32'd1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
            checkOutput($sformatf("to_quiet%0d", k), 32'({data_rvalid_o, bus_err_o}), 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        checkOutput("to_err", 32'(bus_err_o), 32'd1);
        checkOutput("to_drv", 32'(data_rvalid_o), 32'd1);
        checkOutput("to_drd", data_rdata_o, 32'hDEAD_BEEF);
        checkOutput("to_irv", 32'(instr_rvalid_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        checkOutput("to_idle_err", 32'({data_rvalid_o, bus_err_o}), 32'd0);

        // Response arriving exactly on the timeout cycle wins.
        applyStimulus(0, 0, 0, 1, 32'h204, Word_Access, 0, 0, 1, 0, 0);
        checkOutput("tc_dgt", 32'(data_gnt_o), 32'd1);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 1, 32'h55);
        checkOutput("tc_drv", 32'(data_rvalid_o), 32'd1);
        checkOutput("tc_drd", data_rdata_o, 32'h55);
        checkOutput("tc_err", 32'(bus_err_o), 32'd0);

        // Backpressure with a stray rvalid in IDLE.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 32'h400, 0, 0, Byte_Access, 0, 0, 0, (k == 2), 32'h99);
            checkOutput($sformatf("bp_req%0d", k), 32'(mem_bus.mem_req_o), 32'd1);
            checkOutput($sformatf("bp_igt%0d", k), 32'(instr_gnt_o), 32'd0);
            checkOutput($sformatf("bp_rv%0d", k), 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
            checkOutput($sformatf("bp_rd%0d", k), instr_rdata_o, 32'd0);
        end
        applyStimulus(0, 1, 32'h400, 0, 0, Byte_Access, 0, 0, 1, 0, 0);
        checkOutput("bp_igt_rise", 32'(instr_gnt_o), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 1, 32'h400);
        checkOutput("bp_irv", 32'(instr_rvalid_o), 32'd1);
        checkOutput("bp_ird", instr_rdata_o, 32'h400);

        // Build a streak of two, start a third load, then reset mid-read.
        runContention(2, 10'b0);
        applyStimulus(0, 1, 32'h1000, 1, 32'h2000, Word_Access, 0, 0, 1, 0, 0);
        checkOutput("rm_dgt", 32'(data_gnt_o), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 0, 0);
        checkOutput("rm_in_rst", 32'({data_rvalid_o, instr_rvalid_o, bus_err_o, mem_bus.mem_req_o}), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, Byte_Access, 0, 0, 0, 1, 32'h77);
        checkOutput("rm_drv", 32'(data_rvalid_o), 32'd0);
        checkOutput("rm_irv", 32'(instr_rvalid_o), 32'd0);
        checkOutput("rm_drd", data_rdata_o, 32'd0);
        checkOutput("rm_err", 32'(bus_err_o), 32'd0);
        checkOutput("rm_req", 32'(mem_bus.mem_req_o), 32'd0);
        runContention(5, 10'b00000_10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
